// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 raster timing generator and frame-buffer scan-out.
// The 256x240 frame is shown doubled in both axes and centred horizontally;
// the rest of the visible area shows BORDER_IDX, and blanking shows 8'h00.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   pix_en           pixel enable; all state advances only when high
//   fb_addr, fb_rd   frame-buffer read address {y,x} and read strobe
//   fb_data          frame-buffer data, valid one clk after fb_rd
//   vga_buffer_byte  palette index to the colour decoder
//   hsync, vsync     active-low syncs, aligned with vga_buffer_byte
//   de               display enable, aligned with vga_buffer_byte
//   vblank_start     one-pix_en pulse at the first pixel of vertical blank
//   test_mode        colour-bar select, present only when the macro
//                    VGA_SCANOUT_TESTPAT_EN is defined
module vga_scanout #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned H_OFFSET   = 64,
  parameter logic [7:0]  BORDER_IDX = 8'h0F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_en,
  output logic [15:0] fb_addr,
  output logic        fb_rd,
  input  logic [7:0]  fb_data,
  output logic [7:0]  vga_buffer_byte,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        vblank_start
`ifdef VGA_SCANOUT_TESTPAT_EN
  ,
  input  logic        test_mode
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] IMG_X0   = 10'(H_OFFSET);
  localparam logic [9:0] IMG_X1   = 10'(H_OFFSET + 512);
  // Image rows are capped at 480 so y never exceeds 239 (max address EFFF).
  localparam logic [9:0] IMG_Y1   = 10'((V_ACTIVE < 480) ? V_ACTIVE : 480);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic is_image(input logic [9:0] h, input logic [9:0] v);
    return (h >= IMG_X0) && (h < IMG_X1) && (h < H_VIS) && (v < IMG_Y1);
  endfunction

  function automatic logic [15:0] addr_of(input logic [9:0] h, input logic [9:0] v);
    return {8'(v >> 1), 8'((h - IMG_X0) >> 1)};
  endfunction

  // Stage 0: raster counters
  logic [9:0] h_cnt, v_cnt;
  logic [9:0] h_nxt, v_nxt;
  logic       visible, image;
  logic       tp_sel;

  // Stage 1: flags and raw syncs
  logic       img_q, vis_q, hs_q, vs_q, vbl_q;
  logic [7:0] img_byte;

`ifdef VGA_SCANOUT_TESTPAT_EN
  logic       tm_q;
  logic [7:0] tp_q;
`endif

  always_comb begin
    h_nxt   = (h_cnt == H_LAST) ? '0 : h_cnt + 10'd1;
    v_nxt   = v_cnt;
    if (h_cnt == H_LAST) begin
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end
    visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    image   = is_image(h_cnt, v_cnt);
`ifdef VGA_SCANOUT_TESTPAT_EN
    tp_sel   = test_mode;
    img_byte = tm_q ? tp_q : fb_data;
`else
    tp_sel   = 1'b0;
    img_byte = fb_data;
`endif
    fb_rd   = image && pix_en && !tp_sel;
  end

  // fb_addr is a register loaded with the address of the upcoming pixel, so
  // it is valid in the same cycle as the combinational fb_rd strobe and holds
  // its last image address outside the image.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt           <= '0;
      v_cnt           <= '0;
      fb_addr         <= '0;
      img_q           <= 1'b0;
      vis_q           <= 1'b0;
      hs_q            <= 1'b1;
      vs_q            <= 1'b1;
      vbl_q           <= 1'b0;
      vga_buffer_byte <= '0;
      hsync           <= 1'b1;
      vsync           <= 1'b1;
      de              <= 1'b0;
      vblank_start    <= 1'b0;
    end else if (pix_en) begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (is_image(h_nxt, v_nxt)) begin
        fb_addr <= addr_of(h_nxt, v_nxt);
      end
      img_q <= image;
      vis_q <= visible;
      hs_q  <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vs_q  <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
      vbl_q <= (h_cnt == '0) && (v_cnt == V_VIS);
      if (img_q) begin
        vga_buffer_byte <= img_byte;
      end else if (vis_q) begin
        vga_buffer_byte <= BORDER_IDX;
      end else begin
        vga_buffer_byte <= '0;
      end
      de           <= vis_q;
      hsync        <= hs_q;
      vsync        <= vs_q;
      vblank_start <= vbl_q;
    end
  end

`ifdef VGA_SCANOUT_TESTPAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tm_q <= 1'b0;
      tp_q <= '0;
    end else if (pix_en) begin
      tm_q <= test_mode;
      tp_q <= {2'b00, v_cnt[8:7], h_cnt[8:5]};
    end
  end
`endif

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout. Horizontal timing is the default 800-pixel
// line; vertical timing is shortened to 7 lines (4 visible, vsync on line 5)
// so full frames, vblank and wrap-around fit in a short run.
module tb_vga_scanout;

  logic        clk;
  logic        reset_n;
  logic        pix_en;
  logic [15:0] fb_addr;
  logic        fb_rd;
  logic [7:0]  fb_data;
  logic [7:0]  vga_buffer_byte;
  logic        hsync, vsync, de, vblank_start;
  logic        test_mode;

  int tests;
  int errors;
  int pos;   // pixel index since reset release (h = pos % 800)

  vga_scanout #(
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pix_en          (pix_en),
    .fb_addr         (fb_addr),
    .fb_rd           (fb_rd),
    .fb_data         (fb_data),
    .vga_buffer_byte (vga_buffer_byte),
    .hsync           (hsync),
    .vsync           (vsync),
    .de              (de),
    .vblank_start    (vblank_start)
`ifdef VGA_SCANOUT_TESTPAT_EN
    ,
    .test_mode       (test_mode)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: returns the low address byte one clk after a read,
  // a marker value otherwise.
  always @(posedge clk) fb_data <= fb_rd ? fb_addr[7:0] : 8'hA5;

  task automatic tick();
    @(posedge clk);
    if (pix_en) pos++;
    #1;
  endtask

  task automatic goto(input int target);
    while (pos < target) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pix_en = 1'b0; test_mode = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1; pix_en = 1'b1; pos = 0;
    goto(100);
    #3 reset_n = 1'b0;
    #1;
    tests++; if (fb_addr !== 16'h0000) begin errors++; $display("FAIL rst_fb_addr: got %h expected 0000", fb_addr); end
    tests++; if (fb_rd !== 1'b0) begin errors++; $display("FAIL rst_fb_rd: got %b expected 0", fb_rd); end
    tests++; if (vga_buffer_byte !== 8'h00) begin errors++; $display("FAIL rst_byte: got %h expected 00", vga_buffer_byte); end
    tests++; if (hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync: got %b expected 1", hsync); end
    tests++; if (vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync: got %b expected 1", vsync); end
    tests++; if (de !== 1'b0) begin errors++; $display("FAIL rst_de: got %b expected 0", de); end
    tests++; if (vblank_start !== 1'b0) begin errors++; $display("FAIL rst_vblank: got %b expected 0", vblank_start); end
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1; pos = 0;
    tests++; if (de !== 1'b0) begin errors++; $display("FAIL rel_de_p0: got %b expected 0", de); end
    tick();
    tests++; if (de !== 1'b0) begin errors++; $display("FAIL rel_de_p1: got %b expected 0", de); end
    tick();
    tests++; if (de !== 1'b1) begin errors++; $display("FAIL rel_de_p2: got %b expected 1", de); end
    tests++; if (vga_buffer_byte !== 8'h0F) begin errors++; $display("FAIL rel_border_p2: got %h expected 0F", vga_buffer_byte); end
  endtask

  task automatic test_line0_fetch();
    goto(63);
    tests++; if (fb_rd !== 1'b0) begin errors++; $display("FAIL rd_h63: got %b expected 0", fb_rd); end
    tick(); // h=64
    tests++; if (fb_rd !== 1'b1) begin errors++; $display("FAIL rd_h64: got %b expected 1", fb_rd); end
    tests++; if (fb_addr !== 16'h0000) begin errors++; $display("FAIL addr_h64: got %h expected 0000", fb_addr); end
    tick(); // h=65
    tests++; if (fb_addr !== 16'h0000) begin errors++; $display("FAIL addr_h65: got %h expected 0000", fb_addr); end
    tests++; if (vga_buffer_byte !== 8'h0F) begin errors++; $display("FAIL byte_h65: got %h expected 0F", vga_buffer_byte); end
    tick(); // h=66
    tests++; if (fb_addr !== 16'h0001) begin errors++; $display("FAIL addr_h66: got %h expected 0001", fb_addr); end
    tests++; if (vga_buffer_byte !== 8'h00) begin errors++; $display("FAIL byte_h66: got %h expected 00", vga_buffer_byte); end
    tick();
    tests++; if (vga_buffer_byte !== 8'h00) begin errors++; $display("FAIL byte_h67: got %h expected 00", vga_buffer_byte); end
    tick();
    tests++; if (vga_buffer_byte !== 8'h01) begin errors++; $display("FAIL byte_h68: got %h expected 01", vga_buffer_byte); end
    tick();
    tests++; if (vga_buffer_byte !== 8'h01) begin errors++; $display("FAIL byte_h69: got %h expected 01", vga_buffer_byte); end
    goto(575);
    tests++; if (fb_rd !== 1'b1) begin errors++; $display("FAIL rd_h575: got %b expected 1", fb_rd); end
    tests++; if (fb_addr !== 16'h00FF) begin errors++; $display("FAIL addr_h575: got %h expected 00FF", fb_addr); end
    tick();
    tests++; if (fb_rd !== 1'b0) begin errors++; $display("FAIL rd_h576: got %b expected 0", fb_rd); end
    tests++; if (fb_addr !== 16'h00FF) begin errors++; $display("FAIL addr_hold_h576: got %h expected 00FF", fb_addr); end
    tick();
    tests++; if (vga_buffer_byte !== 8'hFF) begin errors++; $display("FAIL byte_h577: got %h expected FF", vga_buffer_byte); end
    tick();
    tests++; if (vga_buffer_byte !== 8'h0F) begin errors++; $display("FAIL byte_h578: got %h expected 0F", vga_buffer_byte); end
    goto(641);
    tests++; if (de !== 1'b1 || vga_buffer_byte !== 8'h0F) begin errors++; $display("FAIL vis_end_h641: de=%b byte=%h expected 1/0F", de, vga_buffer_byte); end
    tick();
    tests++; if (de !== 1'b0 || vga_buffer_byte !== 8'h00) begin errors++; $display("FAIL blank_h642: de=%b byte=%h expected 0/00", de, vga_buffer_byte); end
  endtask

  task automatic test_hsync();
    int low;
    goto(657);
    tests++; if (hsync !== 1'b1) begin errors++; $display("FAIL hs_p657: got %b expected 1", hsync); end
    tick();
    tests++; if (hsync !== 1'b0) begin errors++; $display("FAIL hs_p658: got %b expected 0", hsync); end
    goto(753);
    tests++; if (hsync !== 1'b0) begin errors++; $display("FAIL hs_p753: got %b expected 0", hsync); end
    tick();
    tests++; if (hsync !== 1'b1) begin errors++; $display("FAIL hs_p754: got %b expected 1", hsync); end
    goto(1457);
    tests++; if (hsync !== 1'b1) begin errors++; $display("FAIL hs_p1457: got %b expected 1", hsync); end
    tick();
    tests++; if (hsync !== 1'b0) begin errors++; $display("FAIL hs_p1458: got %b expected 0", hsync); end
    low = 0;
    goto(1600);
    while (pos < 2400) begin
      if (hsync === 1'b0) low++;
      tick();
    end
    tests++; if (low !== 96) begin errors++; $display("FAIL hs_low_width: got %0d expected 96", low); end
  endtask

  task automatic test_row3_addr();
    goto(2975); // v=3, h=575
    tests++; if (fb_rd !== 1'b1 || fb_addr !== 16'h01FF) begin errors++; $display("FAIL addr_v3_h575: rd=%b addr=%h expected 1/01FF", fb_rd, fb_addr); end
    tick();
    tests++; if (fb_rd !== 1'b0) begin errors++; $display("FAIL rd_v3_h576: got %b expected 0", fb_rd); end
  endtask

  task automatic test_vblank_vsync();
    goto(3201);
    tests++; if (vblank_start !== 1'b0) begin errors++; $display("FAIL vbl_p3201: got %b expected 0", vblank_start); end
    tick();
    tests++; if (vblank_start !== 1'b1) begin errors++; $display("FAIL vbl_p3202: got %b expected 1", vblank_start); end
    tests++; if (de !== 1'b0 || vga_buffer_byte !== 8'h00) begin errors++; $display("FAIL vbl_blank_p3202: de=%b byte=%h expected 0/00", de, vga_buffer_byte); end
    tests++; if (fb_rd !== 1'b0) begin errors++; $display("FAIL vbl_rd_p3202: got %b expected 0", fb_rd); end
    tick();
    tests++; if (vblank_start !== 1'b0) begin errors++; $display("FAIL vbl_p3203: got %b expected 0", vblank_start); end
    goto(3264); // v=4, h=64: outside image rows
    tests++; if (fb_rd !== 1'b0) begin errors++; $display("FAIL rd_v4_h64: got %b expected 0", fb_rd); end
    goto(4001);
    tests++; if (vsync !== 1'b1) begin errors++; $display("FAIL vs_p4001: got %b expected 1", vsync); end
    tick();
    tests++; if (vsync !== 1'b0) begin errors++; $display("FAIL vs_p4002: got %b expected 0", vsync); end
    goto(4801);
    tests++; if (vsync !== 1'b0) begin errors++; $display("FAIL vs_p4801: got %b expected 0", vsync); end
    tick();
    tests++; if (vsync !== 1'b1) begin errors++; $display("FAIL vs_p4802: got %b expected 1", vsync); end
  endtask

  task automatic test_wrap();
    goto(5601);
    tests++; if (de !== 1'b0) begin errors++; $display("FAIL wrap_de_p5601: got %b expected 0", de); end
    tick();
    tests++; if (de !== 1'b1) begin errors++; $display("FAIL wrap_de_p5602: got %b expected 1", de); end
    goto(5663);
    tests++; if (fb_addr !== 16'h01FF || fb_rd !== 1'b0) begin errors++; $display("FAIL wrap_hold_p5663: addr=%h rd=%b expected 01FF/0", fb_addr, fb_rd); end
    tick();
    tests++; if (fb_addr !== 16'h0000 || fb_rd !== 1'b1) begin errors++; $display("FAIL wrap_addr_p5664: addr=%h rd=%b expected 0000/1", fb_addr, fb_rd); end
  endtask

  task automatic test_stall();
    goto(6240); // frame 1, v=0, h=640
    pix_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (fb_rd !== 1'b0 || fb_addr !== 16'h00FF || vga_buffer_byte !== 8'h0F ||
          de !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1 || vblank_start !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold_%0d: rd=%b addr=%h byte=%h de=%b hs=%b vs=%b vbl=%b expected 0/00FF/0F/1/1/1/0",
                 i, fb_rd, fb_addr, vga_buffer_byte, de, hsync, vsync, vblank_start);
      end
    end
    pix_en = 1'b1;
    tick(); // h=641
    tests++; if (de !== 1'b1 || vga_buffer_byte !== 8'h0F) begin errors++; $display("FAIL stall_resume_h641: de=%b byte=%h expected 1/0F", de, vga_buffer_byte); end
    tick(); // h=642
    tests++; if (de !== 1'b0 || vga_buffer_byte !== 8'h00) begin errors++; $display("FAIL stall_resume_h642: de=%b byte=%h expected 0/00", de, vga_buffer_byte); end
    goto(6258); // h=658
    tests++; if (hsync !== 1'b0) begin errors++; $display("FAIL stall_hs_h658: got %b expected 0", hsync); end
  endtask

`ifdef VGA_SCANOUT_TESTPAT_EN
  task automatic test_pattern();
    int rd_seen;
    goto(11260); // frame 2, v=0, h=60
    test_mode = 1'b1;
    rd_seen = 0;
    while (pos < 11300) begin
      tick();
      if (fb_rd !== 1'b0) rd_seen++;
      if (pos == 11266) begin
        tests++; if (vga_buffer_byte !== 8'h02) begin errors++; $display("FAIL tp_h66: got %h expected 02", vga_buffer_byte); end
      end
      if (pos == 11298) begin
        tests++; if (vga_buffer_byte !== 8'h03) begin errors++; $display("FAIL tp_h98: got %h expected 03", vga_buffer_byte); end
      end
    end
    tests++; if (rd_seen !== 0) begin errors++; $display("FAIL tp_no_reads: got %0d reads expected 0", rd_seen); end
    test_mode = 1'b0;
  endtask
`endif

  initial begin
    tests = 0; errors = 0; pos = 0;
    reset_n = 1'b0; pix_en = 1'b0; test_mode = 1'b0;
    test_reset();
    test_line0_fetch();
    test_hsync();
    test_row3_addr();
    test_vblank_vsync();
    test_wrap();
    test_stall();
`ifdef VGA_SCANOUT_TESTPAT_EN
    test_pattern();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
